main_ctrl_fsm: RTL and testbench

MAIN_CTRL_FSM -- requirements
Module: main_ctrl_fsm

---
 rtl/main_ctrl_fsm_pkg.sv | 74 +++++++
 rtl/main_ctrl_out_dec.sv | 75 +++++++
 rtl/main_ctrl_fsm.sv | 110 +++++++++++
 tb/tb_main_ctrl_fsm.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/main_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle main control FSM: state encodings,
// opcode constants, ALU-op codes (also used by the ALU control decoder),
// datapath mux select codes and the control-word struct.
package main_ctrl_fsm_pkg;

  localparam int unsigned StateW = 4;
  localparam int unsigned OpW    = 6;
  localparam int unsigned AluOpW = 2;

  // State encodings
  localparam logic [StateW-1:0] StFetch    = 4'd0;
  localparam logic [StateW-1:0] StDecode   = 4'd1;
  localparam logic [StateW-1:0] StMemAddr  = 4'd2;
  localparam logic [StateW-1:0] StMemRead  = 4'd3;
  localparam logic [StateW-1:0] StMemWb    = 4'd4;
  localparam logic [StateW-1:0] StMemWrite = 4'd5;
  localparam logic [StateW-1:0] StExecute  = 4'd6;
  localparam logic [StateW-1:0] StRWb      = 4'd7;
  localparam logic [StateW-1:0] StBranch   = 4'd8;
  localparam logic [StateW-1:0] StJump     = 4'd9;
  localparam logic [StateW-1:0] StAddiEx   = 4'd10;
  localparam logic [StateW-1:0] StAddiWb   = 4'd11;

  // Opcodes
  localparam logic [OpW-1:0] OpRType = 6'b000000;
  localparam logic [OpW-1:0] OpLw    = 6'b100011;
  localparam logic [OpW-1:0] OpSw    = 6'b101011;
  localparam logic [OpW-1:0] OpBeq   = 6'b000100;
  localparam logic [OpW-1:0] OpJ     = 6'b000010;
  localparam logic [OpW-1:0] OpAddi  = 6'b001000;

  // ALU-op codes
  localparam logic [AluOpW-1:0] AluOpAdd   = 2'b00;
  localparam logic [AluOpW-1:0] AluOpSub   = 2'b01;
  localparam logic [AluOpW-1:0] AluOpFunct = 2'b10;

  // ALU B source selects
  localparam logic [1:0] SrcBRt    = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  // PC source selects
  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  typedef struct packed {
    logic              pc_write;
    logic              pc_write_cond;
    logic              i_or_d;
    logic              mem_read;
    logic              mem_write;
    logic              ir_write;
    logic              mem_to_reg;
    logic              reg_dst;
    logic              reg_write;
    logic              alu_src_a;
    logic [1:0]        alu_src_b;
    logic [AluOpW-1:0] alu_op;
    logic [1:0]        pc_source;
  } ctrl_t;

  function automatic logic is_supported_op(input logic [OpW-1:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OpRType, OpLw, OpSw, OpBeq, OpJ, OpAddi: ok = 1'b1;
      default:                                 ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/main_ctrl_out_dec.sv
// Combinational state-to-control-word decoder for main_ctrl_fsm.
// Ports:
//   state_i     - current FSM state
//   mem_ready_i - memory ready (already masked by reset); gates IR/PC load in FETCH
//   ctrl_o      - datapath control word; any field not driven by a state is 0
module main_ctrl_out_dec
  import main_ctrl_fsm_pkg::*;
(
  input  logic [StateW-1:0] state_i,
  input  logic              mem_ready_i,
  output ctrl_t             ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      StFetch: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SrcBFour;
        ctrl_o.alu_op    = AluOpAdd;
        ctrl_o.pc_source = PcSrcAlu;
        // PC+4 and IR load only commit on the cycle the fetch completes
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      StDecode: begin
        // Precompute branch target into ALUOut
        ctrl_o.alu_src_b = SrcBImmSh;
        ctrl_o.alu_op    = AluOpAdd;
      end
      StMemAddr, StAddiEx: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SrcBImm;
        ctrl_o.alu_op    = AluOpAdd;
      end
      StMemRead: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      StMemWrite: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      StMemWb: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      StExecute: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SrcBRt;
        ctrl_o.alu_op    = AluOpFunct;
      end
      StRWb: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      StBranch: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SrcBRt;
        ctrl_o.alu_op        = AluOpSub;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PcSrcAluOut;
      end
      StJump: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PcSrcJump;
      end
      StAddiWb: begin
        ctrl_o.reg_write = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/main_ctrl_fsm.sv
// Multicycle MIPS main control FSM (Moore). Holds the state register and
// next-state logic; control outputs come from main_ctrl_out_dec.
// Ports:
//   i_clk, i_reset      - clock, asynchronous active-high reset
//   i_opcode            - IR opcode field, stable from DECODE onward
//   i_mem_ready         - memory completes the current access this cycle
//   o_pc_write .. o_pc_source - datapath control signals
//   o_invalid           - pulses in DECODE for an unsupported opcode
//   o_state             - current state (debug)
module main_ctrl_fsm
  import main_ctrl_fsm_pkg::*;
#(
  parameter int unsigned N_BITS_OP    = 6,
  parameter int unsigned N_BITS_ALUOP = 2,
  parameter int unsigned N_BITS_STATE = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [N_BITS_OP-1:0]    i_opcode,
  input  logic                    i_mem_ready,
  output logic                    o_pc_write,
  output logic                    o_pc_write_cond,
  output logic                    o_i_or_d,
  output logic                    o_mem_read,
  output logic                    o_mem_write,
  output logic                    o_ir_write,
  output logic                    o_mem_to_reg,
  output logic                    o_reg_dst,
  output logic                    o_reg_write,
  output logic                    o_alu_src_a,
  output logic [1:0]              o_alu_src_b,
  output logic [N_BITS_ALUOP-1:0] o_alu_op,
  output logic [1:0]              o_pc_source,
  output logic                    o_invalid,
  output logic [N_BITS_STATE-1:0] o_state
);

  logic [N_BITS_STATE-1:0] state_q, state_d;
  logic [StateW-1:0]       st, next_st;
  logic [OpW-1:0]          op;
  ctrl_t                   ctrl;

  assign st = StateW'(state_q);
  assign op = OpW'(i_opcode);

  always_comb begin
    next_st = StFetch;
    case (st)
      StFetch: next_st = i_mem_ready ? StDecode : StFetch;
      StDecode: begin
        case (op)
          OpRType:    next_st = StExecute;
          OpLw, OpSw: next_st = StMemAddr;
          OpBeq:      next_st = StBranch;
          OpJ:        next_st = StJump;
          OpAddi:     next_st = StAddiEx;
          default:    next_st = StFetch;
        endcase
      end
      StMemAddr: begin
        if (op == OpLw) begin
          next_st = StMemRead;
        end else if (op == OpSw) begin
          next_st = StMemWrite;
        end else begin
          next_st = StFetch;
        end
      end
      StMemRead:  next_st = i_mem_ready ? StMemWb : StMemRead;
      StMemWrite: next_st = i_mem_ready ? StFetch : StMemWrite;
      StExecute:  next_st = StRWb;
      StAddiEx:   next_st = StAddiWb;
      default:    next_st = StFetch;
    endcase
  end

  assign state_d = N_BITS_STATE'(next_st);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= N_BITS_STATE'(StFetch);
    end else begin
      state_q <= state_d;
    end
  end

  // Reset forces FETCH, but the IR/PC must not load until reset is released
  main_ctrl_out_dec u_out_dec (
    .state_i     (st),
    .mem_ready_i (i_mem_ready & ~i_reset),
    .ctrl_o      (ctrl)
  );

  assign o_pc_write      = ctrl.pc_write;
  assign o_pc_write_cond = ctrl.pc_write_cond;
  assign o_i_or_d        = ctrl.i_or_d;
  assign o_mem_read      = ctrl.mem_read;
  assign o_mem_write     = ctrl.mem_write;
  assign o_ir_write      = ctrl.ir_write;
  assign o_mem_to_reg    = ctrl.mem_to_reg;
  assign o_reg_dst       = ctrl.reg_dst;
  assign o_reg_write     = ctrl.reg_write;
  assign o_alu_src_a     = ctrl.alu_src_a;
  assign o_alu_src_b     = ctrl.alu_src_b;
  assign o_alu_op        = N_BITS_ALUOP'(ctrl.alu_op);
  assign o_pc_source     = ctrl.pc_source;
  assign o_invalid       = (st == StDecode) && !is_supported_op(op);
  assign o_state         = state_q;

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// Directed bench for main_ctrl_fsm. The stimulus process drives one cycle at
// a time and queues the hand-computed state/control word for that cycle; a
// monitor pops and compares on each falling edge.
module tb_main_ctrl_fsm;

  // Control word bit order:
  // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
  //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0],
  //  alu_op[1:0], pc_source[1:0], invalid}
  localparam logic [16:0] WFetchRdy = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [16:0] WFetchWt  = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] WDecode   = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] WDecInv   = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
  localparam logic [16:0] WMemAddr  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] WMemRead  = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] WMemWb    = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [16:0] WMemWrite = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] WExecute  = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] WRWb      = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] WBranch   = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [16:0] WJump     = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
  localparam logic [16:0] WAddiEx   = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] WAddiWb   = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [16:0] w;
  } exp_t;

  logic       clk = 1'b0;
  logic       i_reset;
  logic [5:0] i_opcode;
  logic       i_mem_ready;
  logic       o_pc_write, o_pc_write_cond, o_i_or_d, o_mem_read, o_mem_write;
  logic       o_ir_write, o_mem_to_reg, o_reg_dst, o_reg_write, o_alu_src_a;
  logic [1:0] o_alu_src_b, o_alu_op, o_pc_source;
  logic       o_invalid;
  logic [3:0] o_state;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  main_ctrl_fsm dut (
    .i_clk           (clk),
    .i_reset         (i_reset),
    .i_opcode        (i_opcode),
    .i_mem_ready     (i_mem_ready),
    .o_pc_write      (o_pc_write),
    .o_pc_write_cond (o_pc_write_cond),
    .o_i_or_d        (o_i_or_d),
    .o_mem_read      (o_mem_read),
    .o_mem_write     (o_mem_write),
    .o_ir_write      (o_ir_write),
    .o_mem_to_reg    (o_mem_to_reg),
    .o_reg_dst       (o_reg_dst),
    .o_reg_write     (o_reg_write),
    .o_alu_src_a     (o_alu_src_a),
    .o_alu_src_b     (o_alu_src_b),
    .o_alu_op        (o_alu_op),
    .o_pc_source     (o_pc_source),
    .o_invalid       (o_invalid),
    .o_state         (o_state)
  );

  // Monitor
  logic [16:0] act_w;
  exp_t        cur;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur   = exp_q.pop_front();
      act_w = {o_pc_write, o_pc_write_cond, o_i_or_d, o_mem_read, o_mem_write, o_ir_write,
               o_mem_to_reg, o_reg_dst, o_reg_write, o_alu_src_a, o_alu_src_b,
               o_alu_op, o_pc_source, o_invalid};
      n_cmp++;
      if (o_state !== cur.st || act_w !== cur.w) begin
        n_err++;
        $display("FAIL %s: got state=%0d ctrl=%b, required state=%0d ctrl=%b",
                 cur.tag, o_state, act_w, cur.st, cur.w);
      end
      if (o_mem_read === 1'b1 && o_mem_write === 1'b1) begin
        n_err++;
        $display("FAIL %s_rw_excl: got mem_read=1 mem_write=1, required not both", cur.tag);
      end
    end
  end

  // Drive mem_ready for one cycle and queue what the DUT must show in it
  task automatic step(input string tag, input logic rdy, input logic [3:0] st,
                      input logic [16:0] w);
    exp_t e;
    i_mem_ready = rdy;
    e.tag = tag;
    e.st  = st;
    e.w   = w;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    i_reset     = 1'b0;
    i_mem_ready = 1'b1;
    i_opcode    = 6'b100011;
    #1 i_reset  = 1'b1;
    @(posedge clk);
    #1;
    // Held in reset with memory ready: FETCH decode but no IR/PC load
    step("reset", 1'b1, 4'd0, WFetchWt);
    i_reset = 1'b0;

    // lw, no waits: 0,1,2,3,4
    step("lw_fetch", 1'b1, 4'd0, WFetchRdy);
    step("lw_decode", 1'b1, 4'd1, WDecode);
    step("lw_addr", 1'b1, 4'd2, WMemAddr);
    step("lw_read", 1'b1, 4'd3, WMemRead);
    step("lw_wb", 1'b1, 4'd4, WMemWb);

    // sw, three wait cycles in MEM_WRITE
    i_opcode = 6'b101011;
    step("sw_fetch", 1'b1, 4'd0, WFetchRdy);
    step("sw_decode", 1'b1, 4'd1, WDecode);
    step("sw_addr", 1'b1, 4'd2, WMemAddr);
    step("sw_wait0", 1'b0, 4'd5, WMemWrite);
    step("sw_wait1", 1'b0, 4'd5, WMemWrite);
    step("sw_wait2", 1'b0, 4'd5, WMemWrite);
    step("sw_done", 1'b1, 4'd5, WMemWrite);

    // R-type, with one fetch wait cycle first
    i_opcode = 6'b000000;
    step("r_fetch_wait", 1'b0, 4'd0, WFetchWt);
    step("r_fetch", 1'b1, 4'd0, WFetchRdy);
    step("r_decode", 1'b1, 4'd1, WDecode);
    step("r_exec", 1'b1, 4'd6, WExecute);
    step("r_wb", 1'b1, 4'd7, WRWb);

    // beq then j
    i_opcode = 6'b000100;
    step("beq_fetch", 1'b1, 4'd0, WFetchRdy);
    step("beq_decode", 1'b1, 4'd1, WDecode);
    step("beq_branch", 1'b1, 4'd8, WBranch);
    i_opcode = 6'b000010;
    step("j_fetch", 1'b1, 4'd0, WFetchRdy);
    step("j_decode", 1'b1, 4'd1, WDecode);
    step("j_jump", 1'b1, 4'd9, WJump);

    // addi
    i_opcode = 6'b001000;
    step("addi_fetch", 1'b1, 4'd0, WFetchRdy);
    step("addi_decode", 1'b1, 4'd1, WDecode);
    step("addi_ex", 1'b1, 4'd10, WAddiEx);
    step("addi_wb", 1'b1, 4'd11, WAddiWb);

    // Unsupported opcode: one-cycle invalid in DECODE, back to FETCH
    i_opcode = 6'b111111;
    step("inv_fetch", 1'b1, 4'd0, WFetchRdy);
    step("inv_decode", 1'b1, 4'd1, WDecInv);

    // lw interrupted by reset during a MEM_READ wait
    i_opcode = 6'b100011;
    step("lwr_fetch", 1'b1, 4'd0, WFetchRdy);
    step("lwr_decode", 1'b1, 4'd1, WDecode);
    step("lwr_addr", 1'b1, 4'd2, WMemAddr);
    step("lwr_wait", 1'b0, 4'd3, WMemRead);
    i_reset = 1'b1;
    step("lwr_reset", 1'b0, 4'd0, WFetchWt);
    i_reset = 1'b0;
    step("lwr_refetch", 1'b1, 4'd0, WFetchRdy);
    step("lwr_redecode", 1'b1, 4'd1, WDecode);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
